os_drain_ctrl: RTL and testbench
================================

# os_drain_ctrl

Output drain controller for one column of output-stationary PEs. Sequences the column's result shift chain: issues a one-cycle `load_en`, then one `shift_en` per captured word. Captures the word at the chain tail into a small FIFO and presents results downstream on a valid/ready interface. Sits directly downstream of the PE column and stalls the chain, not the data, when the consumer back-pressures.

## Interface
- `ACC_WIDTH`, 24, accumulator/result width; matches PE shift chain width.
- `ROWS`, 4, number of PEs in the shift chain (≥2).
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥2).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `drain_req`  in  1  start a drain; sampled only in IDLE.
- `drain_busy`  out  1  high from LOAD through the last capture.
- `load_en`  out  1  broadcast to PEs; copies `acc_reg` into the shift register.
- `shift_en`  out  1  broadcast to PEs; advances the chain one position.
- `chain_dat_in`  in  ACC_WIDTH  tail PE `shift_dat_out`.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_dat`  out  ACC_WIDTH  FIFO head data.
- `out_idx`  out  $clog2(ROWS)  PE row index of `out_dat`.
- `out_last`  out  1  head is row 0, the final word of the drain.
- `out_sat`  out  1  head word is saturated (see Configuration).

## Operation
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE → LOAD when `drain_req`.
  - LOAD → SHIFT unconditionally.
  - SHIFT → IDLE on the capture where `cap_cnt == ROWS-1`.
- `load_en = (state==LOAD)`.
- `capture = (state==SHIFT) & !fifo_full`.
- `shift_en = capture`. This includes the final capture; the chain head input is tied 0 by the integrator.
- On capture, push `{chain_dat_in, ROWS-1-cap_cnt, (cap_cnt==ROWS-1), sat}` and increment `cap_cnt`. `cap_cnt` clears on LOAD.
- Output order is row ROWS-1 first, down to row 0.
- Full FIFO: `capture` is 0, `shift_en` stays low, and the chain holds. No data is lost or duplicated.
- Push and pop in the same cycle:
  - When not full, both occur and the count is unchanged.
  - When full, push is blocked even if a pop occurs that cycle. This is registered full and deliberate.
- Empty FIFO: `out_valid` = 0. `out_dat`, `out_idx`, `out_last` and `out_sat` are don't-care but must not be X after reset.
- FIFO pointers wrap modulo FIFO_DEPTH; a separate count of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- `drain_req` in LOAD or SHIFT is ignored, with no queuing.
- The FIFO may still hold words from the previous drain while a new drain starts; ordering is preserved.
- Controller does not gate PE `din_row_en`. The integrator must hold it low from the LOAD cycle until `drain_busy` falls if a fresh accumulation is not intended.

## Timing
- Reset: state=IDLE; `cap_cnt`=0; FIFO empty. All outputs 0: `drain_busy`, `load_en`, `shift_en`, `out_valid`, `out_dat`, `out_idx`, `out_last`, `out_sat`.
- Reset asserted mid-drain aborts at the next edge. FIFO contents are discarded. The PE chain state is not this block's concern.
- `drain_req` in cycle 0 gives:
  - `load_en` in cycle 1;
  - first capture/`shift_en` in cycle 2;
  - `out_valid` in cycle 3.
- No back-pressure: captures occur in cycles 2..ROWS+1 and `drain_busy` is low in cycle ROWS+2. A new `drain_req` can be sampled in cycle ROWS+2.
- Each stall cycle (FIFO full in SHIFT) extends the drain by exactly one cycle.
- FIFO read is combinational from the head entry; a pop is reflected on the next cycle.

## Configuration
- `OS_DRAIN_SAT_FLAG_EN`
  - Defined: `sat = (chain_dat_in == {ACC_WIDTH{1'b1}})`, stored per entry and driven on `out_sat`.
  - Undefined: no storage bit and `out_sat` tied 0. All other behaviour is identical.

## Test plan
- Basic drain, `out_ready`=1, chain model preloaded with rows 0..3 = 0x10, 0x20, 0x30, 0x40:
  - outputs are 0x40/idx3, 0x30/idx2, 0x20/idx1, 0x10/idx0 with `out_last`;
  - `load_en` is seen once in cycle 1;
  - exactly 4 `shift_en` pulses.
- Back-pressure: `out_ready`=0 until FIFO full (4 entries); hold 5 cycles → `shift_en` stays low and nothing is pushed. Release, then all 4 words appear in order and `drain_busy` is low after the last push.
- Full with pop in the same cycle, `out_ready` toggling 1/0 every cycle → no capture while full, no lost or duplicate words, final count is 4.
- `drain_req` held high through a whole drain → exactly one LOAD per IDLE visit. Second drain `load_en` is in cycle ROWS+3, and second-drain words follow first-drain words.
- Assert `rst_n`=0 in cycle 3 of a drain → next cycle all outputs are 0, FIFO is empty, and the FSM is in IDLE.
- With `OS_DRAIN_SAT_FLAG_EN`, row 2 = 0xFFFFFF → `out_sat`=1 only on idx2. Without the macro, `out_sat`=0 throughout.

Source files
------------

// File: rtl/os_drain_ctrl.sv
// -----------------------------------------------------------------------------
// os_drain_ctrl
// Output drain controller for one column of output-stationary PEs.
// A drain issues a single load_en pulse (PEs copy acc_reg into their shift
// registers), then one shift_en per word captured from the chain tail. Words
// are queued in a small FIFO and handed downstream over valid/ready. When the
// consumer back-pressures and the FIFO fills, the chain is stalled (shift_en
// held low) rather than data being dropped.
//
// Optional feature macro: OS_DRAIN_SAT_FLAG_EN
//   defined   : each entry stores a saturation flag (word == all ones),
//               driven on out_sat.
//   undefined : no flag storage, out_sat tied 0.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   drain_req    start a drain (sampled only in IDLE)
//   drain_busy   high from LOAD through the last capture
//   load_en      one-cycle broadcast: acc_reg -> shift register
//   shift_en     broadcast: advance chain one position (== capture)
//   chain_dat_in tail PE shift_dat_out
//   out_valid    FIFO non-empty
//   out_ready    consumer accept
//   out_dat      FIFO head data
//   out_idx      PE row index of out_dat
//   out_last     head word is row 0 (final word of its drain)
//   out_sat      head word saturated (0 when feature disabled)
// -----------------------------------------------------------------------------
module os_drain_ctrl #(
    parameter int ACC_WIDTH  = 24,
    parameter int ROWS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     drain_req,
    output logic                     drain_busy,
    output logic                     load_en,
    output logic                     shift_en,
    input  logic [ACC_WIDTH-1:0]     chain_dat_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_dat,
    output logic [$clog2(ROWS)-1:0]  out_idx,
    output logic                     out_last,
    output logic                     out_sat
);

    localparam int IDX_W = $clog2(ROWS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     cap_cnt_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic [ACC_WIDTH-1:0] dat_mem_r  [FIFO_DEPTH];
    logic [IDX_W-1:0]     idx_mem_r  [FIFO_DEPTH];
    logic                 last_mem_r [FIFO_DEPTH];

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 capture_s;
    logic                 pop_s;
    logic                 cap_last_s;

    // Full is taken from the registered count: a pop in the same cycle does
    // not free a slot for a push until the next cycle.
    assign fifo_full_s  = (count_r == FULL_CNT);
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign capture_s    = (state_r == ST_SHIFT) && !fifo_full_s;
    assign pop_s        = !fifo_empty_s && out_ready;
    assign cap_last_s   = (cap_cnt_r == LAST_CNT);

    assign load_en    = (state_r == ST_LOAD);
    assign shift_en   = capture_s;
    assign drain_busy = (state_r != ST_IDLE);

    // Head of FIFO is read combinationally; entries are reset to zero so the
    // don't-care outputs are never X while the FIFO is empty.
    assign out_valid = !fifo_empty_s;
    assign out_dat   = dat_mem_r[rd_ptr_r];
    assign out_idx   = idx_mem_r[rd_ptr_r];
    assign out_last  = last_mem_r[rd_ptr_r];

`ifdef OS_DRAIN_SAT_FLAG_EN
    logic sat_mem_r [FIFO_DEPTH];
    logic sat_s;

    assign sat_s   = (chain_dat_in == {ACC_WIDTH{1'b1}});
    assign out_sat = sat_mem_r[rd_ptr_r];

    // Saturation flag storage, written alongside each captured word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                sat_mem_r[i] <= 1'b0;
            end
        end else begin
            if (capture_s) begin
                sat_mem_r[wr_ptr_r] <= sat_s;
            end
        end
    end
`else
    assign out_sat = 1'b0;
`endif

    // Drain FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (drain_req) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (capture_s && cap_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and capture counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cap_cnt_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ST_LOAD) begin
                cap_cnt_r <= {IDX_W{1'b0}};
            end else if (capture_s) begin
                cap_cnt_r <= cap_last_s ? {IDX_W{1'b0}} : (cap_cnt_r + IDX_W'(1));
            end
        end
    end

    // Output FIFO: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dat_mem_r[i]  <= {ACC_WIDTH{1'b0}};
                idx_mem_r[i]  <= {IDX_W{1'b0}};
                last_mem_r[i] <= 1'b0;
            end
        end else begin
            if (capture_s) begin
                // Chain tail holds row ROWS-1 first, so the row index counts down.
                dat_mem_r[wr_ptr_r]  <= chain_dat_in;
                idx_mem_r[wr_ptr_r]  <= LAST_CNT - cap_cnt_r;
                last_mem_r[wr_ptr_r] <= cap_last_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({capture_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_os_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_os_drain_ctrl
// Directed self-checking bench for os_drain_ctrl. A behavioural PE chain
// model feeds chain_dat_in from load_en/shift_en. Expected words are queued
// when a drain is requested and compared against every accepted output word.
// An occupancy model (pushes seen on shift_en minus handshakes) checks
// out_valid and that the chain never shifts into a full FIFO.
// -----------------------------------------------------------------------------
module tb_os_drain_ctrl;

    localparam int ACC_WIDTH  = 24;
    localparam int ROWS       = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = $clog2(ROWS);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] dat;
        logic [IDX_W-1:0]     idx;
        logic                 last;
        logic                 sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 drain_req;
    logic                 drain_busy;
    logic                 load_en;
    logic                 shift_en;
    logic [ACC_WIDTH-1:0] chain_dat_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_dat;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 out_sat;

    logic [ACC_WIDTH-1:0] preload [ROWS];
    logic [ACC_WIDTH-1:0] chain   [ROWS];
    exp_t                 sb_q[$];

    int n_checks  = 0;
    int n_fails   = 0;
    int load_cnt  = 0;
    int shift_cnt = 0;
    int pop_cnt   = 0;
    int occ       = 0;

    always #5 clk = ~clk;

    os_drain_ctrl #(
        .ACC_WIDTH  (ACC_WIDTH),
        .ROWS       (ROWS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .drain_req    (drain_req),
        .drain_busy   (drain_busy),
        .load_en      (load_en),
        .shift_en     (shift_en),
        .chain_dat_in (chain_dat_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dat      (out_dat),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .out_sat      (out_sat)
    );

    // PE chain model: row ROWS-1 is the tail, head input tied to zero.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < ROWS; i++) chain[i] <= preload[i];
        end else if (shift_en) begin
            chain[0] <= '0;
            for (int i = 1; i < ROWS; i++) chain[i] <= chain[i-1];
        end
    end
    assign chain_dat_in = chain[ROWS-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_sat(input logic [ACC_WIDTH-1:0] v);
`ifdef OS_DRAIN_SAT_FLAG_EN
        return (v == {ACC_WIDTH{1'b1}});
`else
        return 1'b0;
`endif
    endfunction

    // Queue the words one drain of the current preload should produce.
    task automatic expect_drain();
        exp_t e;
        for (int r = ROWS - 1; r >= 0; r--) begin
            e.dat  = preload[r];
            e.idx  = IDX_W'(r);
            e.last = (r == 0);
            e.sat  = exp_sat(preload[r]);
            sb_q.push_back(e);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample 1ns later.
    task automatic step(input logic req, input logic rdy);
        exp_t e;
        @(negedge clk);
        drain_req = req;
        out_ready = rdy;
        #1;
        if (load_en)  load_cnt++;
        if (shift_en) shift_cnt++;
        if (rst_n) begin
            chk("valid_vs_occ", 32'(out_valid), 32'(occ != 0));
            if (occ == FIFO_DEPTH) chk("no_shift_when_full", 32'(shift_en), 32'd0);
        end
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb_q.size() == 0) begin
                chk("word_with_empty_scoreboard", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("out_dat",  32'(out_dat),  32'(e.dat));
                chk("out_idx",  32'(out_idx),  32'(e.idx));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("out_sat",  32'(out_sat),  32'(e.sat));
            end
        end
        if (rst_n) occ = occ + int'(shift_en) - int'(out_valid && out_ready);
        else       occ = 0;
    endtask

    // Run until scoreboard empty and DUT idle with FIFO empty, bounded.
    task automatic drain_out(input int max_cyc, input logic toggle);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            step(1'b0, toggle ? ~i[0] : 1'b1);
            done = (sb_q.size() == 0) && !drain_busy && !out_valid;
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  32'(drain_busy), 32'd0);
        chk({tag, "_load"},  32'(load_en),    32'd0);
        chk({tag, "_shift"}, 32'(shift_en),   32'd0);
        chk({tag, "_valid"}, 32'(out_valid),  32'd0);
        chk({tag, "_dat"},   32'(out_dat),    32'd0);
        chk({tag, "_idx"},   32'(out_idx),    32'd0);
        chk({tag, "_last"},  32'(out_last),   32'd0);
        chk({tag, "_sat"},   32'(out_sat),    32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        drain_req = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            chain[i]   = '0;
            preload[i] = ACC_WIDTH'((i + 1) * 16);
        end

        // ---- reset state ----
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // ---- basic drain, out_ready = 1 ----
        load_cnt = 0; shift_cnt = 0; pop_cnt = 0;
        expect_drain();
        step(1'b1, 1'b1);                       // cycle 0
        for (int rel = 1; rel <= 7; rel++) begin
            step(1'b0, 1'b1);
            chk("basic_load_en",  32'(load_en),    32'(rel == 1));
            chk("basic_shift_en", 32'(shift_en),   32'(rel >= 2 && rel <= ROWS + 1));
            chk("basic_busy",     32'(drain_busy), 32'(rel >= 1 && rel <= ROWS + 1));
            chk("basic_valid",    32'(out_valid),  32'(rel >= 3 && rel <= ROWS + 2));
        end
        chk("basic_load_cnt",  32'(load_cnt),    32'd1);
        chk("basic_shift_cnt", 32'(shift_cnt),   32'(ROWS));
        chk("basic_pop_cnt",   32'(pop_cnt),     32'(ROWS));
        chk("basic_sb_empty",  32'(sb_q.size()), 32'd0);

        // ---- back-pressure: fill FIFO, then stall a second drain ----
        expect_drain();
        step(1'b1, 1'b0);
        for (int i = 0; i < ROWS + 2; i++) step(1'b0, 1'b0);
        chk("bp_full_valid", 32'(out_valid),  32'd1);
        chk("bp_idle",       32'(drain_busy), 32'd0);
        for (int i = 0; i < ROWS; i++) preload[i] = ACC_WIDTH'(32'h0A0000 + 32'((i + 1) * 17));
        expect_drain();
        shift_cnt = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);                       // LOAD
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("bp_stall_shift", 32'(shift_en),   32'd0);
            chk("bp_stall_busy",  32'(drain_busy), 32'd1);
        end
        chk("bp_stall_cnt", 32'(shift_cnt), 32'd0);
        drain_out(40, 1'b0);
        chk("bp_shift_cnt", 32'(shift_cnt), 32'(ROWS));

        // ---- full with pop in same cycle, out_ready toggling ----
        expect_drain();
        step(1'b1, 1'b0);
        for (int i = 0; i < ROWS + 2; i++) step(1'b0, 1'b0);
        for (int i = 0; i < ROWS; i++) preload[i] = ACC_WIDTH'(32'h5A0000 + 32'(i * 3));
        expect_drain();
        shift_cnt = 0; pop_cnt = 0;
        step(1'b1, 1'b0);
        drain_out(80, 1'b1);
        chk("tog_shift_cnt", 32'(shift_cnt), 32'(ROWS));
        chk("tog_pop_cnt",   32'(pop_cnt),   32'(2 * ROWS));

        // ---- drain_req held high: one LOAD per IDLE visit ----
        load_cnt = 0;
        expect_drain();
        expect_drain();
        for (int rel = 0; rel <= 2 * ROWS + 3; rel++) begin
            step(1'b1, 1'b1);
            if (load_en) chk("held_load_cycle", 32'(rel), (load_cnt == 1) ? 32'd1 : 32'(ROWS + 3));
        end
        drain_out(40, 1'b0);
        chk("held_load_cnt", 32'(load_cnt), 32'd2);

        // ---- reset asserted mid-drain (cycle 3) ----
        expect_drain();
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        rst_n = 1'b0;
        occ   = 0;
        step(1'b0, 1'b0);
        check_all_zero("midrst");
        sb_q.delete();
        rst_n = 1'b1;
        load_cnt = 0; shift_cnt = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("midrst_idle_busy",  32'(drain_busy), 32'd0);
        chk("midrst_idle_valid", 32'(out_valid),  32'd0);
        chk("midrst_no_load",    32'(load_cnt),   32'd0);
        chk("midrst_no_shift",   32'(shift_cnt),  32'd0);

        // ---- saturation flag: row 2 all ones ----
        preload[0] = 24'h000123;
        preload[1] = 24'hFFFFFE;
        preload[2] = 24'hFFFFFF;
        preload[3] = 24'h7FFFFF;
        expect_drain();
        step(1'b1, 1'b1);
        drain_out(30, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard time limit so a hung DUT cannot stall the run.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule
